// File: rtl/la_pkg.sv
// -----------------------------------------------------------------------------
// la_pkg -- shared definitions for the video_capture_la logic analyser.
//   la_state_e : capture / readout state machine encoding
//   la_ptr_w() : address width of the capture buffer (clog2 of its depth)
// -----------------------------------------------------------------------------
package la_pkg;

  typedef enum logic [2:0] {
    LA_IDLE  = 3'd0,
    LA_PRE   = 3'd1,
    LA_ARMED = 3'd2,
    LA_POST  = 3'd3,
    LA_READ  = 3'd4
  } la_state_e;

  function automatic int la_ptr_w(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/la_capture_ram.sv
// -----------------------------------------------------------------------------
// la_capture_ram -- simple dual-port capture buffer, DEPTH x DATA_W.
// One write port, one read port with a registered output, single clock.
// rd_data only updates when rd_en is high, so the read register doubles as
// a pipeline stage that can be stalled.
//   clk      : clock
//   wr_en    : write strobe
//   wr_addr  : write address
//   wr_data  : write data
//   rd_en    : read strobe (loads rd_data on the next edge)
//   rd_addr  : read address
//   rd_data  : registered read data
// -----------------------------------------------------------------------------
module la_capture_ram #(
  parameter int DATA_W = 26,
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  // NOTE: the array has no reset so it maps onto block RAM; every word is
  // written before it is read back, so its power-up contents never matter.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/video_capture_la.sv
// -----------------------------------------------------------------------------
// video_capture_la -- pre/post-trigger logic analyser for a video probe bus.
// Samples data_i into a circular buffer, waits for PRE_DEPTH history samples,
// hunts for a trigger, fills the rest of the buffer and then streams all DEPTH
// words out oldest-first on a valid/ready interface.
//
// Build option: define LA_EDGE_TRIG_EN to add edge qualification of the
// trigger (trig_edge_i bits must toggle versus the previous sample).
//
// Ports:
//   clk, rst           : clock, synchronous active-high reset
//   data_i             : probe sample
//   arm_i              : start a capture (IDLE or READ)
//   abort_i            : return to IDLE from any state
//   trig_mask_i        : bits taking part in the level compare
//   trig_value_i       : level compare value
//   trig_edge_i        : bits that must toggle (LA_EDGE_TRIG_EN only)
//   busy_o             : capture in progress (PRE/ARMED/POST)
//   triggered_o        : sticky trigger flag
//   done_o             : readout in progress (READ)
//   rd_valid_o/rd_data_o/rd_last_o/rd_ready_i : readout stream
// -----------------------------------------------------------------------------
module video_capture_la
  import la_pkg::*;
#(
  parameter int DATA_W    = 26,
  parameter int DEPTH     = 1024,
  parameter int PRE_DEPTH = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_i,
  input  logic              arm_i,
  input  logic              abort_i,
  input  logic [DATA_W-1:0] trig_mask_i,
  input  logic [DATA_W-1:0] trig_value_i,
`ifdef LA_EDGE_TRIG_EN
  input  logic [DATA_W-1:0] trig_edge_i,
`endif
  output logic              busy_o,
  output logic              triggered_o,
  output logic              done_o,
  output logic              rd_valid_o,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              rd_last_o,
  input  logic              rd_ready_i
);

  localparam int PTR_W  = la_ptr_w(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int POST_N = DEPTH - PRE_DEPTH - 1;

  localparam logic [PTR_W-1:0] PRE_LAST  = PTR_W'(PRE_DEPTH - 1);
  localparam logic [PTR_W-1:0] POST_LAST = PTR_W'(POST_N - 1);
  localparam logic [CNT_W-1:0] RD_END    = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] RD_LAST   = CNT_W'(DEPTH - 1);

  la_state_e         state;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  cnt;
  logic              triggered_q;

  // Readout pipeline: RAM output register (q_*) feeding the output register.
  logic [CNT_W-1:0]  rd_cnt;
  logic              q_valid;
  logic              q_last;
  logic              out_valid;
  logic              out_last;
  logic [DATA_W-1:0] out_data;
  logic [DATA_W-1:0] ram_q;

  logic              capturing;
  logic              level_hit;
  logic              edge_hit;
  logic              trig_hit;
  logic              out_load;
  logic              rd_en;
  logic [PTR_W-1:0]  rd_addr;

  assign capturing = state inside {LA_PRE, LA_ARMED, LA_POST};
  assign level_hit = ((data_i ^ trig_value_i) & trig_mask_i) == '0;

`ifdef LA_EDGE_TRIG_EN
  logic [DATA_W-1:0] prev_q;
  assign edge_hit = ((data_i ^ prev_q) & trig_edge_i) == trig_edge_i;

  // Loaded on every capture cycle, so the first ARMED cycle compares
  // against the last PRE sample.
  always_ff @(posedge clk) begin
    if (rst)            prev_q <= '0;
    else if (capturing) prev_q <= data_i;
  end
`else
  assign edge_hit = 1'b1;
`endif

  assign trig_hit = (state == LA_ARMED) && level_hit && edge_hit;

  // The output register may take a new word when empty or being drained;
  // the RAM stage may be refilled when empty or being moved forward.
  assign out_load = !out_valid || rd_ready_i;
  assign rd_en    = (state == LA_READ) && (rd_cnt != RD_END) && (!q_valid || out_load);
  // Oldest word sits at the final write pointer; the adder wraps naturally.
  assign rd_addr  = wr_ptr + rd_cnt[PTR_W-1:0];

  la_capture_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (PTR_W)
  ) u_ram (
    .clk     (clk),
    .wr_en   (capturing),
    .wr_addr (wr_ptr),
    .wr_data (data_i),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (ram_q)
  );

  // NOTE: all state below is updated with non-blocking assignments so every
  // register samples the pre-edge values of the others, as the hardware does.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= LA_IDLE;
      wr_ptr      <= '0;
      cnt         <= '0;
      triggered_q <= 1'b0;
      rd_cnt      <= '0;
      q_valid     <= 1'b0;
      q_last      <= 1'b0;
      out_valid   <= 1'b0;
      out_last    <= 1'b0;
      out_data    <= '0;
    end else begin
      if (abort_i) begin
        state       <= LA_IDLE;
        triggered_q <= 1'b0;
        q_valid     <= 1'b0;
        out_valid   <= 1'b0;
        out_last    <= 1'b0;
      end else begin
        case (state)
          LA_IDLE: begin
            if (arm_i) begin
              state       <= LA_PRE;
              cnt         <= '0;
              triggered_q <= 1'b0;
            end
          end

          LA_PRE: begin
            if (cnt == PRE_LAST) begin
              state <= LA_ARMED;
              cnt   <= '0;
            end else begin
              cnt <= cnt + PTR_W'(1);
            end
          end

          LA_ARMED: begin
            if (trig_hit) begin
              triggered_q <= 1'b1;
              cnt         <= '0;
              rd_cnt      <= '0;
              q_valid     <= 1'b0;
              state       <= (POST_N == 0) ? LA_READ : LA_POST;
            end
          end

          LA_POST: begin
            if (cnt == POST_LAST) begin
              state   <= LA_READ;
              rd_cnt  <= '0;
              q_valid <= 1'b0;
            end else begin
              cnt <= cnt + PTR_W'(1);
            end
          end

          LA_READ: begin
            if (arm_i) begin
              // Restart capture; any word in flight is dropped.
              state       <= LA_PRE;
              cnt         <= '0;
              triggered_q <= 1'b0;
              q_valid     <= 1'b0;
              out_valid   <= 1'b0;
              out_last    <= 1'b0;
            end else begin
              if (rd_en) begin
                rd_cnt <= rd_cnt + CNT_W'(1);
                q_last <= (rd_cnt == RD_LAST);
              end
              q_valid <= rd_en || (q_valid && !out_load);
              if (out_load) begin
                out_valid <= q_valid;
                out_last  <= q_valid && q_last;
                if (q_valid) out_data <= ram_q;
              end
              if (out_valid && rd_ready_i && out_last) begin
                state     <= LA_IDLE;
                out_valid <= 1'b0;
                out_last  <= 1'b0;
                q_valid   <= 1'b0;
              end
            end
          end

          default: state <= LA_IDLE;
        endcase
      end

      // Pointer tracks the RAM write strobe, which follows the current state.
      if (capturing) wr_ptr <= wr_ptr + PTR_W'(1);
    end
  end

  assign busy_o      = capturing;
  assign triggered_o = triggered_q;
  assign done_o      = (state == LA_READ);
  assign rd_valid_o  = out_valid;
  assign rd_data_o   = out_data;
  assign rd_last_o   = out_last;

endmodule

// File: tb/tb_video_capture_la.sv
// -----------------------------------------------------------------------------
// tb_video_capture_la -- self-checking bench for video_capture_la
// (DATA_W=8, DEPTH=16, PRE_DEPTH=4, data_i is a free-running 8-bit counter).
// Each capture is armed so that the first PRE sample is the requested start
// value. The reference model treats the capture as the sequence of samples
// start, start+1, ... and finds the trigger index by scanning that sequence;
// the expected readout is the DEPTH-sample window around it.
// -----------------------------------------------------------------------------
module tb_video_capture_la;

  localparam int DATA_W    = 8;
  localparam int DEPTH     = 16;
  localparam int PRE_DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  data_i;
  logic        arm_i;
  logic        abort_i;
  logic [7:0]  trig_mask_i;
  logic [7:0]  trig_value_i;
`ifdef LA_EDGE_TRIG_EN
  logic [7:0]  trig_edge_i;
`endif
  logic        busy_o;
  logic        triggered_o;
  logic        done_o;
  logic        rd_valid_o;
  logic [7:0]  rd_data_o;
  logic        rd_last_o;
  logic        rd_ready_i;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  video_capture_la #(
    .DATA_W    (DATA_W),
    .DEPTH     (DEPTH),
    .PRE_DEPTH (PRE_DEPTH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .data_i       (data_i),
    .arm_i        (arm_i),
    .abort_i      (abort_i),
    .trig_mask_i  (trig_mask_i),
    .trig_value_i (trig_value_i),
`ifdef LA_EDGE_TRIG_EN
    .trig_edge_i  (trig_edge_i),
`endif
    .busy_o       (busy_o),
    .triggered_o  (triggered_o),
    .done_o       (done_o),
    .rd_valid_o   (rd_valid_o),
    .rd_data_o    (rd_data_o),
    .rd_last_o    (rd_last_o),
    .rd_ready_i   (rd_ready_i)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One clock; outputs are sampled 1 ns after the edge, and the counter
  // advances so the next edge writes the next value.
  task automatic tick();
    @(posedge clk);
    #1;
    data_i = data_i + 8'd1;
    cyc++;
  endtask

  // Index (0-based, counted from the first PRE sample) of the trigger sample.
  function automatic int model_trig(input logic [7:0] start, input logic [7:0] mask,
                                    input logic [7:0] value, input logic [7:0] edge_bits);
    logic [7:0] d;
    logic [7:0] p;
    for (int t = PRE_DEPTH; t < PRE_DEPTH + 600; t++) begin
      d = start + 8'(t);
      p = start + 8'(t - 1);
      if ((((d ^ value) & mask) == 8'd0) && (((d ^ p) & edge_bits) == edge_bits)) return t;
    end
    return -1;
  endfunction

  // ready_mode: 0 = always ready, 1 = toggle 1,0,..., 2 = random.
  // rst_at >= 0 asserts rst while word rst_at is being presented.
  task automatic run_capture(input string name, input logic [7:0] start, input logic [7:0] mask,
                             input logic [7:0] value, input logic [7:0] edge_bits,
                             input int ready_mode, input int rst_at,
                             input bit chk_first, input logic [7:0] exp_first);
    int t_idx, budget, done_cyc, valid_cyc, first_x, last_x, stall_err, last_err;
    bit ended, tog, prev_stall, prev_last;
    logic [7:0] prev_data, arm_at, exp_w;
    logic [7:0] got[$];
    bit got_last[$];

    t_idx = model_trig(start, mask, value, edge_bits);
    trig_mask_i  = mask;
    trig_value_i = value;
`ifdef LA_EDGE_TRIG_EN
    trig_edge_i  = edge_bits;
`endif
    arm_at = start - 8'd1;
    while (data_i != arm_at) tick();
    arm_i = 1'b1;
    tick();
    arm_i = 1'b0;

    done_cyc = -1; valid_cyc = -1; first_x = -1; last_x = -1;
    stall_err = 0; ended = 1'b0; tog = 1'b1; prev_stall = 1'b0;
    prev_data = '0; prev_last = 1'b0; budget = 0;

    while (budget < 1200) begin
      if (done_o && done_cyc < 0) done_cyc = cyc;
      if (rd_valid_o && valid_cyc < 0) valid_cyc = cyc;
      if (prev_stall && (!rd_valid_o || rd_data_o !== prev_data || rd_last_o !== prev_last))
        stall_err++;
      if (rst_at >= 0 && rd_valid_o && got.size() == rst_at) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check({name, "_rst_outputs"},
              {26'd0, busy_o, triggered_o, done_o, rd_valid_o, rd_last_o, (rd_data_o != 8'd0)},
              32'd0);
        check({name, "_rst_data"}, {24'd0, rd_data_o}, 32'd0);
        return;
      end
      case (ready_mode)
        0:       rd_ready_i = 1'b1;
        1:       begin rd_ready_i = tog; tog = ~tog; end
        default: rd_ready_i = 1'($urandom_range(0, 1));
      endcase
      #1;
      prev_stall = rd_valid_o && !rd_ready_i;
      prev_data  = rd_data_o;
      prev_last  = rd_last_o;
      if (rd_valid_o && rd_ready_i) begin
        got.push_back(rd_data_o);
        got_last.push_back(rd_last_o);
        if (first_x < 0) first_x = cyc;
        last_x = cyc;
        if (rd_last_o) begin
          ended = 1'b1;
          tick();
          break;
        end
      end
      tick();
      budget++;
    end
    rd_ready_i = 1'b1;

    check({name, "_finished"}, {31'd0, ended}, 32'd1);
    check({name, "_word_count"}, got.size(), DEPTH);
    if (t_idx < 0) begin
      check({name, "_model_has_trigger"}, 32'd0, 32'd1);
      return;
    end
    for (int k = 0; k < got.size() && k < DEPTH; k++) begin
      exp_w = start + 8'(t_idx - PRE_DEPTH + k);
      check($sformatf("%s_word%0d", name, k), {24'd0, got[k]}, {24'd0, exp_w});
    end
    if (chk_first && got.size() > 0)
      check({name, "_first_word"}, {24'd0, got[0]}, {24'd0, exp_first});
    last_err = 0;
    foreach (got_last[k]) if (got_last[k] != (k == DEPTH - 1)) last_err++;
    check({name, "_last_flag_errors"}, last_err, 0);
    check({name, "_stall_stability_errors"}, stall_err, 0);
    check({name, "_valid_latency"}, valid_cyc - done_cyc, 2);
    if (ready_mode == 0) check({name, "_one_per_cycle_span"}, last_x - first_x, DEPTH - 1);
    check({name, "_after_last_done_valid"}, {30'd0, done_o, rd_valid_o}, 32'd0);
    check({name, "_triggered_sticky"}, {31'd0, triggered_o}, 32'd1);
  endtask

  typedef struct {
    logic [7:0] start;
    logic [7:0] mask;
    logic [7:0] value;
    logic [7:0] edge_bits;
    int         ready_mode;
    logic [7:0] exp_first;
  } vec_t;

  vec_t vecs[4];

  initial begin
    logic [7:0] r_start, r_mask, r_value, r_edge;
    int budget;

    vecs[0] = '{start: 8'h00, mask: 8'hFF, value: 8'h0A, edge_bits: 8'h00, ready_mode: 0, exp_first: 8'h06};
    vecs[1] = '{start: 8'h00, mask: 8'hFF, value: 8'h01, edge_bits: 8'h00, ready_mode: 0, exp_first: 8'hFD};
    vecs[2] = '{start: 8'h00, mask: 8'hFF, value: 8'h0A, edge_bits: 8'h00, ready_mode: 1, exp_first: 8'h06};
    vecs[3] = '{start: 8'h30, mask: 8'h00, value: 8'h5A, edge_bits: 8'h00, ready_mode: 0, exp_first: 8'h30};

    rst = 1'b1; arm_i = 1'b0; abort_i = 1'b0; rd_ready_i = 1'b1;
    data_i = 8'd0; trig_mask_i = 8'd0; trig_value_i = 8'd0;
`ifdef LA_EDGE_TRIG_EN
    trig_edge_i = 8'd0;
`endif
    repeat (3) tick();
    rst = 1'b0;
    check("reset_flags", {27'd0, busy_o, triggered_o, done_o, rd_valid_o, rd_last_o}, 32'd0);
    check("reset_data", {24'd0, rd_data_o}, 32'd0);
    tick();
    check("idle_without_arm", {31'd0, busy_o}, 32'd0);

    for (int i = 0; i < 4; i++)
      run_capture($sformatf("vec%0d", i), vecs[i].start, vecs[i].mask, vecs[i].value,
                  vecs[i].edge_bits, vecs[i].ready_mode, -1, 1'b1, vecs[i].exp_first);

    // Abort during POST, with arm raised in the same cycle.
    trig_mask_i = 8'hFF; trig_value_i = 8'h0A;
    while (data_i != 8'hFF) tick();
    arm_i = 1'b1; tick(); arm_i = 1'b0;
    budget = 0;
    while (!triggered_o && budget < 400) begin tick(); budget++; end
    check("abort_reached_post", {30'd0, triggered_o, busy_o}, 32'd3);
    tick(); tick();
    abort_i = 1'b1; arm_i = 1'b1;
    tick();
    abort_i = 1'b0; arm_i = 1'b0;
    check("abort_flags", {28'd0, busy_o, triggered_o, done_o, rd_valid_o}, 32'd0);
    run_capture("rearm_after_abort", 8'h00, 8'hFF, 8'h0A, 8'h00, 0, -1, 1'b1, 8'h06);

    // Reset in the middle of readout, then a normal capture.
    run_capture("rst_mid_read", 8'h00, 8'hFF, 8'h0A, 8'h00, 0, 7, 1'b0, 8'h00);
    run_capture("capture_after_rst", 8'h00, 8'hFF, 8'h0A, 8'h00, 0, -1, 1'b1, 8'h06);

`ifdef LA_EDGE_TRIG_EN
    run_capture("edge_first_armed", 8'h00, 8'h00, 8'h00, 8'h01, 0, -1, 1'b1, 8'h00);
`endif

    // Randomised captures against the model.
    for (int i = 0; i < 5; i++) begin
      r_start = 8'($urandom);
      r_mask  = 8'($urandom);
      r_value = 8'($urandom);
`ifdef LA_EDGE_TRIG_EN
      case ($urandom_range(0, 2))
        0:       r_edge = 8'h00;
        1:       r_edge = 8'h01;
        default: r_edge = 8'h03;
      endcase
`else
      r_edge = 8'h00;
`endif
      if (model_trig(r_start, r_mask, r_value, r_edge) < 0) r_mask = 8'h00;
      run_capture($sformatf("rand%0d", i), r_start, r_mask, r_value, r_edge, 2, -1, 1'b0, 8'h00);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/video_capture_la.md
VIDEO_CAPTURE_LA -- requirements
Module: video_capture_la

Interface
REQ-001 SHALL have parameter DATA_W, default 26, meaning probe width (red[7:0], green[7:0], blue[7:0], hSync, vSync packed MSB-first).
REQ-002 SHALL have parameter DEPTH, default 1024, meaning capture buffer words; power of two, ≥ 8.
REQ-003 SHALL have parameter PRE_DEPTH, default 256, meaning pre-trigger samples; 1 ≤ PRE_DEPTH < DEPTH.
REQ-004 SHALL have port clk  input  1  the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst  input  1  reset; synchronous and active-high.
REQ-006 SHALL have port data_i  input  DATA_W  probe sample, taken every cycle while capturing.
REQ-007 SHALL have port arm_i  input  1  one-cycle pulse starting a capture.
REQ-008 SHALL have port abort_i  input  1  cancels capture or readout.
REQ-009 SHALL have port trig_mask_i  input  DATA_W  bits taking part in the level compare.
REQ-010 SHALL have port trig_value_i  input  DATA_W  level compare value.
REQ-011 SHALL have port trig_edge_i  input  DATA_W  bits that must change versus the previous sample; present only with LA_EDGE_TRIG_EN.
REQ-012 SHALL have port busy_o  output  1  high in PRE, ARMED, POST.
REQ-013 SHALL have port triggered_o  output  1  trigger seen; sticky until next arm, abort or reset.
REQ-014 SHALL have port done_o  output  1  high in READ.
REQ-015 SHALL have ports rd_valid_o (output, 1), rd_data_o (output, DATA_W), rd_last_o (output, 1) and rd_ready_i (input, 1) forming a valid/ready readout stream.

Function
REQ-016 SHALL implement states IDLE, PRE, ARMED, POST, READ.
REQ-017 SHALL go IDLE→PRE on arm_i; arm_i outside IDLE/READ SHALL be ignored; arm_i in READ SHALL restart in PRE and drop the stream.
REQ-018 SHALL write data_i to a circular buffer at wr_ptr every cycle in PRE/ARMED/POST; wr_ptr wraps DEPTH-1→0.
REQ-019 SHALL leave PRE for ARMED after exactly PRE_DEPTH writes; the trigger SHALL NOT be evaluated in PRE.
REQ-020 SHALL assert trigger when ((data_i ^ trig_value_i) & trig_mask_i) == 0 and the edge term (REQ-034) holds; an all-zero mask triggers on the first ARMED cycle.
REQ-021 SHALL write the trigger sample in ARMED, set triggered_o next cycle, enter POST, and write DEPTH-PRE_DEPTH-1 further samples, then enter READ.
REQ-022 SHALL, in READ, stream all DEPTH words oldest-first from the final wr_ptr; word PRE_DEPTH (0-based) SHALL be the trigger sample.
REQ-023 SHALL set rd_valid_o 2 cycles after entering READ (1-cycle RAM read latency plus output register).
REQ-024 SHALL hold rd_data_o/rd_last_o stable while rd_valid_o && !rd_ready_i; a word transfers on valid && ready.
REQ-025 SHALL sustain one word per cycle with rd_ready_i held high.
REQ-026 SHALL assert rd_last_o with word DEPTH-1; after it transfers, the block SHALL return to IDLE, with done_o and rd_valid_o low the next cycle.
REQ-027 SHALL, on abort_i in any state, enter IDLE the next cycle: rd_valid_o=0, busy_o=0, triggered_o=0; abort_i SHALL win over a simultaneous arm_i.
REQ-028 SHALL hold trig_* constant from arm to READ; changes in that window give undefined trigger results but SHALL NOT corrupt buffer order.

Reset
REQ-029 SHALL, on rst, enter IDLE and set busy_o, triggered_o, done_o, rd_valid_o, rd_last_o to 0, rd_data_o to 0, wr_ptr to 0 and the previous-sample register to 0; buffer contents are not reset.
REQ-030 SHALL let rst override arm_i/abort_i and abort any state mid-operation.

Configuration
REQ-031 SHALL compile edge triggering only under LA_EDGE_TRIG_EN.
REQ-032 SHALL, with LA_EDGE_TRIG_EN, register the previous sample, loading it in PRE/ARMED/POST; the first ARMED cycle compares against the last PRE sample.
REQ-033 SHALL, without LA_EDGE_TRIG_EN, omit trig_edge_i and the previous-sample register.
REQ-034 SHALL define the edge term as ((data_i ^ prev) & trig_edge_i) == trig_edge_i with the macro, and true without it.

Structure
REQ-035 SHALL place the state enum and a ptr-width function (clog2 of DEPTH) in shared package la_pkg.
REQ-036 SHALL use one sub-module, la_capture_ram: simple dual-port, DEPTH×DATA_W, registered read, single clk.

Verification (DATA_W=8, DEPTH=16, PRE_DEPTH=4, data_i = free-running 8-bit counter)
REQ-037 SHALL cover: arm at data 0x00, mask 0xFF, value 0x0A, ready=1 -> 16 words 0x06..0x15 at one per cycle, rd_last_o on 0x15, triggered_o=1.
REQ-038 SHALL cover: arm at 0x00, value 0x01 -> match during PRE ignored; trigger on the wrapped 0x01; readout 0xFD,0xFE,0xFF,0x00,0x01..0x0C.
REQ-039 SHALL cover: REQ-037 stimulus with rd_ready_i toggling 1,0 -> same 16 words, no loss or duplicates, data stable while stalled.
REQ-040 SHALL cover: abort_i pulsed during POST -> IDLE next cycle, all flags 0; re-arm reproduces REQ-037 output.
REQ-041 SHALL cover: LA_EDGE_TRIG_EN, mask 0, edge 0x01 -> trigger on the first ARMED cycle; readout word 4 = 0x04.
REQ-042 SHALL cover: rst asserted mid-READ at word 7 -> all outputs 0 next cycle; arm_i then captures normally.
